disk_block_ctrl: RTL and testbench

DISK_BLOCK_CTRL -- requirements
Module: disk_block_ctrl

---
 rtl/disk_block_ctrl_pkg.sv | 31 +++
 rtl/disk_block_ctrl_if.sv | 26 ++
 rtl/disk_block_buf.sv | 39 +++
 rtl/disk_block_ctrl.sv | 169 ++++++++++++++++
 tb/tb_disk_block_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disk_block_ctrl_pkg.sv
// Shared definitions for the disk block controller.
// Holds the transfer FSM state encoding, the default block geometry,
// the bit positions of the CPU instruction word, and the storage
// word-address helper used by the controller.
package disk_block_ctrl_pkg;

    localparam int BLOCK_WORDS_DEF = 128;
    localparam int IDX_W_DEF       = 7;

    // CPU instruction word layout
    localparam int WE_BIT  = 31;  // 1 = write
    localparam int SEL_BIT = 30;  // 1 = disk, 0 = block buffer
    localparam int BLK_MSB = 29;  // [BLK_MSB:0] = block offset

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        WR_FETCH = 3'd2,
        WR_REQ   = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Storage word address of word idx inside block blk. The shift is
    // done at 32 bits so high block numbers wrap modulo 2^32.
    function automatic logic [31:0] st_word_addr(input logic [BLK_MSB:0] blk,
                                                 input logic [31:0]      idx,
                                                 input int unsigned      idx_w);
        return ({2'b00, blk} << idx_w) + idx;
    endfunction

endpackage

// File: rtl/disk_block_ctrl_if.sv
// Backing-storage bus between the block controller (master) and the
// storage device (slave).
//   st_req   : request, held until st_ack
//   st_we    : 1 = write, 0 = read
//   st_addr  : storage word address
//   st_wdata : write data
//   st_rdata : read data, valid with st_ack
//   st_ack   : one-cycle completion per request
interface disk_block_ctrl_if;
    logic        st_req;
    logic        st_we;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [31:0] st_rdata;
    logic        st_ack;

    modport master (
        output st_req, st_we, st_addr, st_wdata,
        input  st_rdata, st_ack
    );

    modport slave (
        input  st_req, st_we, st_addr, st_wdata,
        output st_rdata, st_ack
    );
endinterface

// File: rtl/disk_block_buf.sv
// Block buffer: BLOCK_WORDS x 32 RAM, one synchronous write port and one
// synchronous read port (read data registered, read-before-write on a
// same-address collision).
//   clk, rst : clock, synchronous reset (clears only the read register)
//   we, waddr, wdata : write port
//   raddr, rdata     : read port, rdata valid one cycle after raddr
module disk_block_buf
    import disk_block_ctrl_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [BLOCK_WORDS];

    // Array is never reset so buffer contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/disk_block_ctrl.sv
// Disk block controller: CPU-visible block buffer plus an FSM that moves
// whole blocks between the buffer and backing storage.
//   clk, rst           : clock, synchronous active-high reset
//   stb, instruction   : CPU strobe and instruction word (we/sel/block)
//   write_pause        : pulse, start buffer -> storage block write
//   read_pause         : pulse, start storage -> buffer block read
//   disk_addr          : CPU byte address into the buffer
//   disk_data_out      : CPU write data
//   disk_data_in       : CPU read data, one cycle after disk_addr (idle)
//   disk_operate_done  : one-cycle pulse at end of a block transfer
//   busy               : high whenever the FSM is not idle
//   st                 : backing-storage bus (master side)
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | CPU owns the buffer; waiting for read_pause/write_pause
// RD_REQ   | storage read of word idx outstanding; ack fills buffer
// WR_FETCH | buffer word idx being read out for the storage write
// WR_REQ   | storage write of word idx outstanding, data held stable
// DONE     | transfer complete, done pulse high for this cycle
module disk_block_ctrl
    import disk_block_ctrl_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stb,
    input  logic [31:0]         instruction,
    input  logic                write_pause,
    input  logic                read_pause,
    input  logic [IDX_W+1:0]    disk_addr,
    input  logic [31:0]         disk_data_out,
    output logic [31:0]         disk_data_in,
    output logic                disk_operate_done,
    output logic                busy,
    disk_block_ctrl_if.master   st
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [BLK_MSB:0] blk;
    logic             last_word;
    logic [31:0]      next_addr;

    logic             cpu_we;
    logic             fill_we;
    logic             buf_we;
    logic [IDX_W-1:0] buf_waddr;
    logic [31:0]      buf_wdata;
    logic [IDX_W-1:0] buf_raddr;
    logic [31:0]      buf_rdata;
    logic             addr_lsb_unused;

    assign addr_lsb_unused = &{1'b0, disk_addr[1:0]};

    assign last_word = (idx == IDX_W'(BLOCK_WORDS - 1));
    assign next_addr = st_word_addr(blk, 32'(idx) + 32'd1, IDX_W);

    // While busy the FSM owns both buffer ports; the CPU is locked out.
    assign cpu_we    = stb & instruction[WE_BIT] & ~instruction[SEL_BIT] & ~busy;
    assign fill_we   = (state == RD_REQ) & st.st_req & st.st_ack;
    assign buf_we    = cpu_we | fill_we;
    assign buf_waddr = busy ? idx : disk_addr[IDX_W+1:2];
    assign buf_wdata = busy ? st.st_rdata : disk_data_out;
    assign buf_raddr = busy ? idx : disk_addr[IDX_W+1:2];

    disk_block_buf #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .IDX_W       (IDX_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    // The buffer read register doubles as the write-data register: during
    // WR_REQ the read address stays at idx and nothing writes the buffer,
    // so the fetched word is held stable until st_ack.
    assign disk_data_in = buf_rdata;
    assign st.st_wdata  = buf_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            idx               <= '0;
            blk               <= '0;
            busy              <= 1'b0;
            disk_operate_done <= 1'b0;
            st.st_req         <= 1'b0;
            st.st_we          <= 1'b0;
            st.st_addr        <= '0;
        end else begin
            disk_operate_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_pause) begin
                        blk        <= instruction[BLK_MSB:0];
                        idx        <= '0;
                        st.st_addr <= st_word_addr(instruction[BLK_MSB:0], 32'd0, IDX_W);
                        busy       <= 1'b1;
                        state      <= WR_FETCH;
                    end else if (read_pause) begin
                        blk        <= instruction[BLK_MSB:0];
                        idx        <= '0;
                        st.st_addr <= st_word_addr(instruction[BLK_MSB:0], 32'd0, IDX_W);
                        st.st_req  <= 1'b1;
                        st.st_we   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RD_REQ;
                    end
                end

                RD_REQ: begin
                    if (st.st_req && st.st_ack) begin
                        // Request drops for one cycle after every ack.
                        st.st_req <= 1'b0;
                        idx       <= idx + 1'b1;
                        if (last_word) begin
                            disk_operate_done <= 1'b1;
                            state             <= DONE;
                        end else begin
                            st.st_addr <= next_addr;
                        end
                    end else begin
                        st.st_req <= 1'b1;
                    end
                end

                WR_FETCH: begin
                    st.st_req <= 1'b1;
                    st.st_we  <= 1'b1;
                    state     <= WR_REQ;
                end

                WR_REQ: begin
                    if (st.st_req && st.st_ack) begin
                        st.st_req <= 1'b0;
                        st.st_we  <= 1'b0;
                        idx       <= idx + 1'b1;
                        if (last_word) begin
                            disk_operate_done <= 1'b1;
                            state             <= DONE;
                        end else begin
                            st.st_addr <= next_addr;
                            state      <= WR_FETCH;
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disk_block_ctrl.sv
// Directed bench for disk_block_ctrl with a simple storage responder that
// acks each request after a fixed delay and returns ~address as read data.
module tb_disk_block_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic [31:0] instruction;
    logic        write_pause;
    logic        read_pause;
    logic [8:0]  disk_addr;
    logic [31:0] disk_data_out;
    logic [31:0] disk_data_in;
    logic        disk_operate_done;
    logic        busy;

    disk_block_ctrl_if sif();

    disk_block_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stb               (stb),
        .instruction       (instruction),
        .write_pause       (write_pause),
        .read_pause        (read_pause),
        .disk_addr         (disk_addr),
        .disk_data_out     (disk_data_out),
        .disk_data_in      (disk_data_in),
        .disk_operate_done (disk_operate_done),
        .busy              (busy),
        .st                (sif)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // storage responder state
    bit          stor_en  = 1'b0;
    bit          spur_ack = 1'b0;
    bit          clr_cnt  = 1'b0;
    int          delay    = 2;
    int          cnt      = 0;
    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    logic [31:0] wr_addr [128];
    logic [31:0] wr_data [128];
    logic [31:0] rd_addr [128];
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we;

    // Transfers are logged once the DUT has consumed the ack.
    always @(negedge clk) begin
        if (clr_cnt) begin
            rd_cnt   = 0;
            wr_cnt   = 0;
            done_cnt = 0;
        end
        if (disk_operate_done === 1'b1) done_cnt++;
        if (!stor_en) begin
            sif.st_ack   = spur_ack;
            sif.st_rdata = 32'h5A5A_5A5A;
            cnt          = 0;
        end else if (sif.st_ack) begin
            sif.st_ack = 1'b0;
            if (cap_we) begin
                if (wr_cnt < 128) begin
                    wr_addr[wr_cnt] = cap_addr;
                    wr_data[wr_cnt] = cap_wdata;
                end
                wr_cnt++;
            end else begin
                if (rd_cnt < 128) rd_addr[rd_cnt] = cap_addr;
                rd_cnt++;
            end
        end else if (sif.st_req === 1'b1) begin
            cnt++;
            if (cnt >= delay) begin
                sif.st_ack   = 1'b1;
                sif.st_rdata = ~sif.st_addr;
                cap_addr     = sif.st_addr;
                cap_we       = sif.st_we;
                cap_wdata    = sif.st_wdata;
                cnt          = 0;
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (disk_operate_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stb = 1'b0; instruction = '0; write_pause = 1'b0;
        read_pause = 1'b0; disk_addr = '0; disk_data_out = '0;
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0 || disk_operate_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status busy=%b done=%b want 0 0", busy, disk_operate_done);
        end
        tests_run++;
        if (sif.st_req !== 1'b0 || sif.st_we !== 1'b0 || sif.st_addr !== 32'h0 || sif.st_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_storage req=%b we=%b addr=%h wdata=%h want all 0",
                     sif.st_req, sif.st_we, sif.st_addr, sif.st_wdata);
        end
        tests_run++;
        if (disk_data_in !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data_in got=%h want 00000000", disk_data_in);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cpu_rw();
        stb = 1'b1; instruction = 32'h8000_0000; disk_addr = 9'h004; disk_data_out = 32'hDEAD_BEEF;
        tick();
        disk_addr = 9'h1FC; disk_data_out = 32'h1234_5678;
        tick();
        stb = 1'b0; instruction = '0; disk_addr = 9'h004;
        tick();
        tests_run++;
        if (disk_data_in !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL cpu_read_004 got=%h want deadbeef", disk_data_in);
        end
        disk_addr = 9'h1FC;
        tick();
        tests_run++;
        if (disk_data_in !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL cpu_read_1fc got=%h want 12345678", disk_data_in);
        end
        disk_addr = 9'h006;
        tick();
        tests_run++;
        if (disk_data_in !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL cpu_read_byte_lsb got=%h want deadbeef", disk_data_in);
        end
    endtask

    task automatic test_block_write();
        bit ok;
        for (int i = 0; i < 128; i++) begin
            stb = 1'b1; instruction = 32'h8000_0000;
            disk_addr = 9'(i * 4); disk_data_out = 32'(i);
            tick();
        end
        stb = 1'b0; instruction = '0;
        stor_en = 1'b1; delay = 2;
        clear_counts();
        instruction = 32'd3; write_pause = 1'b1;
        tick();
        write_pause = 1'b0; instruction = '0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_busy_start got=%b want 1", busy);
        end
        wait_done(3000, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL write_timeout done=0 want done within 3000 cycles");
        end
        tick(); tick();
        tests_run++;
        if (done_cnt !== 1 || busy !== 1'b0 || sif.st_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_end done_cnt=%0d busy=%b req=%b want 1 0 0", done_cnt, busy, sif.st_req);
        end
        tests_run++;
        if (wr_cnt !== 128 || rd_cnt !== 0) begin
            tests_failed++;
            $display("FAIL write_count writes=%0d reads=%0d want 128 0", wr_cnt, rd_cnt);
        end
        for (int i = 0; i < 128; i++) begin
            tests_run++;
            if (wr_addr[i] !== 32'(384 + i) || wr_data[i] !== 32'(i)) begin
                tests_failed++;
                $display("FAIL write_word%0d addr=%h data=%h want %h %h",
                         i, wr_addr[i], wr_data[i], 32'(384 + i), 32'(i));
            end
        end
    endtask

    task automatic test_read_wrap();
        bit ok;
        clear_counts();
        instruction = 32'h3FFF_FFFF; read_pause = 1'b1;
        tick();
        read_pause = 1'b0; instruction = '0;
        tests_run++;
        if (sif.st_req !== 1'b1 || sif.st_we !== 1'b0 || sif.st_addr !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("FAIL read_first_req req=%b we=%b addr=%h want 1 0 ffffff80",
                     sif.st_req, sif.st_we, sif.st_addr);
        end
        wait_done(3000, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL read_timeout done=0 want done within 3000 cycles");
        end
        tick(); tick();
        tests_run++;
        if (done_cnt !== 1 || busy !== 1'b0 || rd_cnt !== 128 || wr_cnt !== 0) begin
            tests_failed++;
            $display("FAIL read_end done_cnt=%0d busy=%b reads=%0d writes=%0d want 1 0 128 0",
                     done_cnt, busy, rd_cnt, wr_cnt);
        end
        for (int i = 0; i < 128; i++) begin
            tests_run++;
            if (rd_addr[i] !== 32'hFFFF_FF80 + 32'(i)) begin
                tests_failed++;
                $display("FAIL read_addr%0d got=%h want %h", i, rd_addr[i], 32'hFFFF_FF80 + 32'(i));
            end
        end
        for (int i = 0; i < 128; i++) begin
            disk_addr = 9'(i * 4);
            tick();
            tests_run++;
            if (disk_data_in !== 32'h7F - 32'(i)) begin
                tests_failed++;
                $display("FAIL read_buf%0d got=%h want %h", i, disk_data_in, 32'h7F - 32'(i));
            end
        end
    endtask

    task automatic test_ignore_busy();
        bit ok;
        clear_counts();
        instruction = 32'd5; write_pause = 1'b1;
        tick();
        write_pause = 1'b0; instruction = '0;
        repeat (10) tick();
        read_pause = 1'b1; stb = 1'b1; instruction = 32'h8000_0009;
        disk_addr = 9'h000; disk_data_out = 32'hBAD0_BAD0;
        tick();
        read_pause = 1'b0; stb = 1'b0; instruction = '0;
        wait_done(3000, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL busy_timeout done=0 want done within 3000 cycles");
        end
        tick(); tick();
        tests_run++;
        if (done_cnt !== 1 || wr_cnt !== 128 || rd_cnt !== 0) begin
            tests_failed++;
            $display("FAIL busy_counts done_cnt=%0d writes=%0d reads=%0d want 1 128 0",
                     done_cnt, wr_cnt, rd_cnt);
        end
        for (int i = 0; i < 128; i++) begin
            tests_run++;
            if (wr_addr[i] !== 32'(640 + i) || wr_data[i] !== 32'h7F - 32'(i)) begin
                tests_failed++;
                $display("FAIL busy_word%0d addr=%h data=%h want %h %h",
                         i, wr_addr[i], wr_data[i], 32'(640 + i), 32'h7F - 32'(i));
            end
        end
        disk_addr = 9'h000;
        tick();
        tests_run++;
        if (disk_data_in !== 32'h0000_007F) begin
            tests_failed++;
            $display("FAIL busy_cpu_write_dropped got=%h want 0000007f", disk_data_in);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        clear_counts();
        instruction = 32'd1; read_pause = 1'b1;
        tick();
        read_pause = 1'b0; instruction = '0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rd_cnt == 50) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL abort_timeout reads=%0d want 50 within 1000 cycles", rd_cnt);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0 || sif.st_req !== 1'b0 || disk_operate_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle busy=%b req=%b done=%b want 0 0 0", busy, sif.st_req, disk_operate_done);
        end
        rst = 1'b0; stor_en = 1'b0;
        tick();
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        repeat (5) tick();
        tests_run++;
        if (busy !== 1'b0 || sif.st_req !== 1'b0 || done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL abort_spurious busy=%b req=%b done_cnt=%0d want 0 0 0", busy, sif.st_req, done_cnt);
        end
        disk_addr = 9'h000;
        tick();
        tests_run++;
        if (disk_data_in !== 32'hFFFF_FF7F) begin
            tests_failed++;
            $display("FAIL abort_buf0 got=%h want ffffff7f", disk_data_in);
        end
        disk_addr = 9'(49 * 4);
        tick();
        tests_run++;
        if (disk_data_in !== 32'hFFFF_FF4E) begin
            tests_failed++;
            $display("FAIL abort_buf49 got=%h want ffffff4e", disk_data_in);
        end
        disk_addr = 9'(50 * 4);
        tick();
        tests_run++;
        if (disk_data_in !== 32'h0000_004D) begin
            tests_failed++;
            $display("FAIL abort_buf50 got=%h want 0000004d", disk_data_in);
        end
    endtask

    task automatic test_both_pulses();
        bit ok;
        stor_en = 1'b1;
        clear_counts();
        instruction = 32'd2; write_pause = 1'b1; read_pause = 1'b1;
        tick();
        write_pause = 1'b0; read_pause = 1'b0; instruction = '0;
        tick();
        tests_run++;
        if (sif.st_req !== 1'b1 || sif.st_we !== 1'b1 || sif.st_addr !== 32'd256) begin
            tests_failed++;
            $display("FAIL both_first_req req=%b we=%b addr=%h want 1 1 00000100",
                     sif.st_req, sif.st_we, sif.st_addr);
        end
        wait_done(3000, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL both_timeout done=0 want done within 3000 cycles");
        end
        tick(); tick();
        tests_run++;
        if (done_cnt !== 1 || wr_cnt !== 128 || rd_cnt !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL both_counts done_cnt=%0d writes=%0d reads=%0d busy=%b want 1 128 0 0",
                     done_cnt, wr_cnt, rd_cnt, busy);
        end
        tests_run++;
        if (wr_addr[0] !== 32'd256 || wr_addr[127] !== 32'd383 || wr_data[0] !== 32'hFFFF_FF7F) begin
            tests_failed++;
            $display("FAIL both_words first=%h last=%h data0=%h want 00000100 0000017f ffffff7f",
                     wr_addr[0], wr_addr[127], wr_data[0]);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_block_write();
        test_read_wrap();
        test_ignore_busy();
        test_reset_abort();
        test_both_pulses();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
